// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard/forwarding unit.
// Stage bookkeeping record and forward-select encoding.
package pipe_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 3;
  localparam int MAX_ADDR_W = 8;

  typedef logic [2:0] fwd_sel_t;

  localparam fwd_sel_t FWD_RF = 3'd0;

  typedef struct packed {
    logic                  valid;
    logic [MAX_ADDR_W-1:0] rd;
    logic                  we;
    logic                  load;
  } stage_info_t;

endpackage

// File: rtl/pipe_stage_info_reg.sv
// One tracking stage: holds {valid, rd, we, load} of an in-flight op.
// Async clear, freeze on hold, bubble insert when requested.
import pipe_pkg::*;

module pipe_stage_info_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        hold,
  input  logic        bubble,
  input  stage_info_t d,
  output stage_info_t q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (!hold) begin
      q <= bubble ? '0 : d;
    end
  end

endmodule

// File: rtl/pipe_hazard_fwd_unit.sv
// RAW hazard tracker: forwards youngest result to ID, stalls on load-use.
// Optional perf counters when PIPE_HAZARD_PERF_EN is defined.
import pipe_pkg::*;

module pipe_hazard_fwd_unit #(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int STAGES   = 3,
  parameter int LOAD_RDY = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     hold_i,
  input  logic                     flush_i,
  input  logic                     id_valid_i,
  input  logic [ADDR_W-1:0]        id_rd_i,
  input  logic                     id_we_i,
  input  logic                     id_load_i,
  input  logic [ADDR_W-1:0]        id_rs1_i,
  input  logic                     id_use1_i,
  input  logic [ADDR_W-1:0]        id_rs2_i,
  input  logic                     id_use2_i,
  input  logic [DATA_W-1:0]        rf_data1_i,
  input  logic [DATA_W-1:0]        rf_data2_i,
  input  logic [STAGES*DATA_W-1:0] res_data_i,
`ifdef PIPE_HAZARD_PERF_EN
  output logic [31:0]              stall_cnt_o,
  output logic [31:0]              fwd_cnt_o,
`endif
  output logic                     stall_o,
  output fwd_sel_t                 fwd_sel1_o,
  output fwd_sel_t                 fwd_sel2_o,
  output logic [DATA_W-1:0]        op1_o,
  output logic [DATA_W-1:0]        op2_o
);

  // st[0] is the ID entry, st[1..STAGES] are EX..WB
  stage_info_t st [0:STAGES];
  logic        haz1;
  logic        haz2;

  assign st[0] = '{
    valid: id_valid_i,
    rd:    MAX_ADDR_W'(id_rd_i),
    we:    id_we_i,
    load:  id_load_i
  };

  for (genvar s = 1; s <= STAGES; s++) begin : g_stage
    pipe_stage_info_reg u_reg (
      .clk    (clk),
      .rst    (rst),
      .hold   (hold_i),
      .bubble ((s == 1) ? (stall_o | flush_i) : 1'b0),
      .d      (st[s-1]),
      .q      (st[s])
    );
  end

  // Walk oldest to youngest so the youngest match overwrites
  always_comb begin
    fwd_sel1_o = FWD_RF;
    fwd_sel2_o = FWD_RF;
    op1_o      = rf_data1_i;
    op2_o      = rf_data2_i;
    haz1       = 1'b0;
    haz2       = 1'b0;
    for (int s = STAGES; s >= 1; s--) begin
      if (id_valid_i && id_use1_i && st[s].valid && st[s].we &&
          st[s].rd == MAX_ADDR_W'(id_rs1_i)) begin
        fwd_sel1_o = fwd_sel_t'(s);
        op1_o      = res_data_i[s*DATA_W-1 -: DATA_W];
        haz1       = st[s].load && (s < LOAD_RDY);
      end
      if (id_valid_i && id_use2_i && st[s].valid && st[s].we &&
          st[s].rd == MAX_ADDR_W'(id_rs2_i)) begin
        fwd_sel2_o = fwd_sel_t'(s);
        op2_o      = res_data_i[s*DATA_W-1 -: DATA_W];
        haz2       = st[s].load && (s < LOAD_RDY);
      end
    end
  end

  // Flush drops the stall unless the chain is frozen anyway
  assign stall_o = (haz1 | haz2) & (hold_i | ~flush_i);

`ifdef PIPE_HAZARD_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_o <= '0;
      fwd_cnt_o   <= '0;
    end else begin
      if (stall_o && !hold_i && stall_cnt_o != 32'hFFFF_FFFF)
        stall_cnt_o <= stall_cnt_o + 32'd1;
      if ((fwd_sel1_o != FWD_RF || fwd_sel2_o != FWD_RF) && !stall_o &&
          fwd_cnt_o != 32'hFFFF_FFFF)
        fwd_cnt_o <= fwd_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_fwd_unit.sv
// Directed bench for pipe_hazard_fwd_unit (default parameters).
// Perf counter checks compile in with PIPE_HAZARD_PERF_EN.
module tb_pipe_hazard_fwd_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        hold_i, flush_i;
  logic        id_valid_i, id_we_i, id_load_i;
  logic [2:0]  id_rd_i, id_rs1_i, id_rs2_i;
  logic        id_use1_i, id_use2_i;
  logic [15:0] rf_data1_i, rf_data2_i;
  logic [47:0] res_data_i;
  logic        stall_o;
  logic [2:0]  fwd_sel1_o, fwd_sel2_o;
  logic [15:0] op1_o, op2_o;
`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] stall_cnt_o, fwd_cnt_o;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_hazard_fwd_unit dut (
    .clk        (clk),
    .rst        (rst),
    .hold_i     (hold_i),
    .flush_i    (flush_i),
    .id_valid_i (id_valid_i),
    .id_rd_i    (id_rd_i),
    .id_we_i    (id_we_i),
    .id_load_i  (id_load_i),
    .id_rs1_i   (id_rs1_i),
    .id_use1_i  (id_use1_i),
    .id_rs2_i   (id_rs2_i),
    .id_use2_i  (id_use2_i),
    .rf_data1_i (rf_data1_i),
    .rf_data2_i (rf_data2_i),
    .res_data_i (res_data_i),
`ifdef PIPE_HAZARD_PERF_EN
    .stall_cnt_o(stall_cnt_o),
    .fwd_cnt_o  (fwd_cnt_o),
`endif
    .stall_o    (stall_o),
    .fwd_sel1_o (fwd_sel1_o),
    .fwd_sel2_o (fwd_sel2_o),
    .op1_o      (op1_o),
    .op2_o      (op2_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic id_idle();
    id_valid_i = 1'b0; id_we_i = 1'b0; id_load_i = 1'b0;
    id_rd_i = 3'd0; id_rs1_i = 3'd0; id_rs2_i = 3'd0;
    id_use1_i = 1'b0; id_use2_i = 1'b0;
    hold_i = 1'b0; flush_i = 1'b0;
  endtask

  task automatic issue(input logic [2:0] rd, input logic ld);
    id_idle();
    id_valid_i = 1'b1; id_we_i = 1'b1; id_load_i = ld; id_rd_i = rd;
  endtask

  task automatic read_ops(input logic [2:0] r1, input logic u1,
                          input logic [2:0] r2, input logic u2);
    id_idle();
    id_valid_i = 1'b1;
    id_rs1_i = r1; id_use1_i = u1;
    id_rs2_i = r2; id_use2_i = u2;
    #1;
  endtask

  task automatic drain();
    id_idle();
    repeat (4) tick();
  endtask

  task automatic test_reset();
    id_idle();
    rf_data1_i = 16'h1234; rf_data2_i = 16'h5678; res_data_i = '0;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    read_ops(3'd1, 1'b1, 3'd2, 1'b1);
    total++;
    if (stall_o !== 1'b0) begin
      bad++; $display("FAIL reset_stall got=%b want=0", stall_o);
    end
    total++;
    if (fwd_sel1_o !== 3'd0 || fwd_sel2_o !== 3'd0) begin
      bad++; $display("FAIL reset_sel got=%0d/%0d want=0/0", fwd_sel1_o, fwd_sel2_o);
    end
    total++;
    if (op1_o !== 16'h1234) begin
      bad++; $display("FAIL reset_op1 got=%h want=1234", op1_o);
    end
  endtask

  task automatic test_fwd_ex();
    issue(3'd1, 1'b0);
    tick();
    res_data_i[15:0] = 16'h00AA;
    read_ops(3'd1, 1'b1, 3'd0, 1'b0);
    total++;
    if (fwd_sel1_o !== 3'd1) begin
      bad++; $display("FAIL ex_sel1 got=%0d want=1", fwd_sel1_o);
    end
    total++;
    if (op1_o !== 16'h00AA) begin
      bad++; $display("FAIL ex_op1 got=%h want=00aa", op1_o);
    end
    total++;
    if (stall_o !== 1'b0) begin
      bad++; $display("FAIL ex_stall got=%b want=0", stall_o);
    end
    drain();
  endtask

  task automatic test_load_use();
    issue(3'd2, 1'b1);
    tick();
    res_data_i[31:16] = 16'hBEEF;
    read_ops(3'd0, 1'b0, 3'd2, 1'b1);
    total++;
    if (stall_o !== 1'b1 || fwd_sel2_o !== 3'd1) begin
      bad++; $display("FAIL lu_stall got=%b/%0d want=1/1", stall_o, fwd_sel2_o);
    end
    tick();
    total++;
    if (stall_o !== 1'b0) begin
      bad++; $display("FAIL lu_stall_len got=%b want=0", stall_o);
    end
    total++;
    if (fwd_sel2_o !== 3'd2 || op2_o !== 16'hBEEF) begin
      bad++; $display("FAIL lu_fwd got=%0d/%h want=2/beef", fwd_sel2_o, op2_o);
    end
    drain();
`ifdef PIPE_HAZARD_PERF_EN
    total++;
    if (stall_cnt_o !== 32'd1) begin
      bad++; $display("FAIL perf_stall got=%0d want=1", stall_cnt_o);
    end
`endif
  endtask

  task automatic test_youngest();
    issue(3'd3, 1'b0); tick();
    issue(3'd4, 1'b0); tick();
    issue(3'd3, 1'b0); tick();
    res_data_i = {16'h0033, 16'h0022, 16'h0011};
    read_ops(3'd3, 1'b1, 3'd4, 1'b1);
    total++;
    if (fwd_sel1_o !== 3'd1 || op1_o !== 16'h0011) begin
      bad++; $display("FAIL young_op1 got=%0d/%h want=1/0011", fwd_sel1_o, op1_o);
    end
    total++;
    if (fwd_sel2_o !== 3'd2 || op2_o !== 16'h0022) begin
      bad++; $display("FAIL young_op2 got=%0d/%h want=2/0022", fwd_sel2_o, op2_o);
    end
    tick();
    read_ops(3'd0, 1'b0, 3'd4, 1'b1);
    total++;
    if (fwd_sel2_o !== 3'd3 || op2_o !== 16'h0033) begin
      bad++; $display("FAIL wb_fwd got=%0d/%h want=3/0033", fwd_sel2_o, op2_o);
    end
    drain();
  endtask

  task automatic test_flush_hold();
    res_data_i = {16'h0C03, 16'h0B02, 16'h0A01};
    issue(3'd2, 1'b1); tick();
    read_ops(3'd0, 1'b0, 3'd2, 1'b1);
    id_we_i = 1'b1; id_rd_i = 3'd5; flush_i = 1'b1;
    #1;
    total++;
    if (stall_o !== 1'b0) begin
      bad++; $display("FAIL flush_stall got=%b want=0", stall_o);
    end
    tick();
    read_ops(3'd5, 1'b1, 3'd2, 1'b1);
    total++;
    if (fwd_sel1_o !== 3'd0 || op1_o !== 16'h1234) begin
      bad++; $display("FAIL flush_kill got=%0d/%h want=0/1234", fwd_sel1_o, op1_o);
    end
    total++;
    if (fwd_sel2_o !== 3'd2 || stall_o !== 1'b0) begin
      bad++; $display("FAIL flush_adv got=%0d/%b want=2/0", fwd_sel2_o, stall_o);
    end
    drain();
    issue(3'd2, 1'b1); tick();
    read_ops(3'd0, 1'b0, 3'd2, 1'b1);
    hold_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if (stall_o !== 1'b1 || fwd_sel2_o !== 3'd1) begin
        bad++; $display("FAIL hold_%0d got=%b/%0d want=1/1", i, stall_o, fwd_sel2_o);
      end
      if (i < 3) tick();
    end
    hold_i = 1'b0;
    tick();
    total++;
    if (stall_o !== 1'b0 || fwd_sel2_o !== 3'd2) begin
      bad++; $display("FAIL hold_rel got=%b/%0d want=0/2", stall_o, fwd_sel2_o);
    end
    drain();
  endtask

  task automatic test_async_reset();
    issue(3'd1, 1'b0); tick();
    issue(3'd2, 1'b0); tick();
    issue(3'd3, 1'b1); tick();
    read_ops(3'd1, 1'b1, 3'd3, 1'b1);
    total++;
    if (fwd_sel1_o !== 3'd3 || stall_o !== 1'b1) begin
      bad++; $display("FAIL pre_rst got=%0d/%b want=3/1", fwd_sel1_o, stall_o);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (stall_o !== 1'b0 || fwd_sel1_o !== 3'd0 || fwd_sel2_o !== 3'd0) begin
      bad++; $display("FAIL async_rst got=%b/%0d/%0d want=0/0/0", stall_o, fwd_sel1_o, fwd_sel2_o);
    end
`ifdef PIPE_HAZARD_PERF_EN
    total++;
    if (stall_cnt_o !== 32'd0 || fwd_cnt_o !== 32'd0) begin
      bad++; $display("FAIL perf_rst got=%0d/%0d want=0/0", stall_cnt_o, fwd_cnt_o);
    end
`endif
    #1 rst = 1'b0;
    tick();
    read_ops(3'd1, 1'b1, 3'd3, 1'b1);
    total++;
    if (stall_o !== 1'b0 || op1_o !== 16'h1234 || op2_o !== 16'h5678) begin
      bad++; $display("FAIL post_rst got=%b/%h/%h want=0/1234/5678", stall_o, op1_o, op2_o);
    end
  endtask

  initial begin
    rst = 1'b1;
    id_idle();
    rf_data1_i = 16'h1234; rf_data2_i = 16'h5678; res_data_i = '0;
    test_reset();
    test_fwd_ex();
    test_load_use();
    test_youngest();
    test_flush_hold();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
